// File: rtl/seq_detector_param.sv
// Serial bit-pattern detector: compares the last PATTERN_W accepted bits against PATTERN.
// Define SEQ_DET_COUNT_EN to build the saturating match counter and its clear_count logic.
module seq_detector_param #(
    parameter int                   PATTERN_W = 4,
    parameter logic [PATTERN_W-1:0] PATTERN   = 4'b1011,
    parameter int                   COUNT_W   = 8
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic                           enable,
    input  logic                           a,
    input  logic                           overlap,
    input  logic                           clear_count,
    output logic                           y,
    output logic [$clog2(PATTERN_W+1)-1:0] state,
    output logic [COUNT_W-1:0]             match_count
);

    localparam int ST_W = $clog2(PATTERN_W + 1);

    typedef logic [ST_W-1:0] fill_t;

    localparam fill_t FILL_0    = '0;
    localparam fill_t FILL_FULL = fill_t'(PATTERN_W);

    generate
        if (PATTERN_W < 2 || PATTERN_W > 32) begin : g_bad_width
            $fatal(1, "seq_detector_param: PATTERN_W must be in 2..32");
        end
    endgenerate

    logic [PATTERN_W-1:0] hist_q, hist_d;
    fill_t                state_q, state_d;
    logic                 y_q, y_d;
    logic [PATTERN_W-1:0] hist_n;
    fill_t                fill_n;
    logic                 hit;

    // Stage 0: shift in the accepted bit and decide the hit and next fill level
    always_comb begin
        hist_d  = hist_q;
        state_d = state_q;
        y_d     = 1'b0;
        hist_n  = {hist_q[PATTERN_W-2:0], a};
        fill_n  = (state_q == FILL_FULL) ? FILL_FULL : state_q + fill_t'(1);
        hit     = 1'b0;
        if (enable) begin
            hit     = (fill_n == FILL_FULL) && (hist_n == PATTERN);
            hist_d  = hist_n;
            state_d = (hit && !overlap) ? FILL_0 : fill_n;
            y_d     = hit;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            hist_q  <= '0;
            state_q <= FILL_0;
            y_q     <= 1'b0;
        end else begin
            hist_q  <= hist_d;
            state_q <= state_d;
            y_q     <= y_d;
        end
    end

    assign y     = y_q;
    assign state = state_q;

`ifdef SEQ_DET_COUNT_EN
    logic [COUNT_W-1:0] count_q, count_d;

    function automatic logic [COUNT_W-1:0] sat_inc(input logic [COUNT_W-1:0] v);
        return (&v) ? v : v + COUNT_W'(1);
    endfunction

    // Clear wins over a same-cycle hit
    always_comb begin
        count_d = count_q;
        if (clear_count) begin
            count_d = '0;
        end else if (hit) begin
            count_d = sat_inc(count_q);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign match_count = count_q;
`else
    logic unused_clear;
    assign unused_clear = clear_count;
    assign match_count  = '0;
`endif

endmodule

// File: tb/tb_seq_detector_param.sv
// Directed bench for seq_detector_param (PATTERN_W=4, PATTERN=4'b1011, COUNT_W=2)
// with a bit-queue reference model checked every cycle.
module tb_seq_detector_param;

    localparam int         W    = 4;
    localparam logic [3:0] PAT  = 4'b1011;
    localparam int         CW   = 2;
`ifdef SEQ_DET_COUNT_EN
    localparam bit         CNT_EN = 1'b1;
`else
    localparam bit         CNT_EN = 1'b0;
`endif

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          enable = 1'b0;
    logic          a = 1'b0;
    logic          overlap = 1'b0;
    logic          clear_count = 1'b0;
    logic          y;
    logic [2:0]    state;
    logic [CW-1:0] match_count;

    int n_pass  = 0;
    int n_total = 0;
    bit chk_on  = 1'b0;

    seq_detector_param #(
        .PATTERN_W(W),
        .PATTERN  (PAT),
        .COUNT_W  (CW)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .enable     (enable),
        .a          (a),
        .overlap    (overlap),
        .clear_count(clear_count),
        .y          (y),
        .state      (state),
        .match_count(match_count)
    );

    always #5 clock = ~clock;

    // Reference model: accepted bits kept as a queue, fill counts bits since the last restart
    bit q_bits[$];
    int m_fill = 0;
    int m_y    = 0;
    int m_cnt  = 0;

    always @(posedge clock) begin
        bit hitm;
        hitm = 1'b0;
        if (reset) begin
            q_bits.delete();
            m_fill = 0;
            m_y    = 0;
            m_cnt  = 0;
        end else begin
            if (enable) begin
                q_bits.push_back(a);
                if (q_bits.size() > W) void'(q_bits.pop_front());
                m_fill = (m_fill < W) ? m_fill + 1 : W;
                if (m_fill == W) begin
                    hitm = 1'b1;
                    for (int i = 0; i < W; i++)
                        if (q_bits[i] != PAT[W-1-i]) hitm = 1'b0;
                end
                if (hitm && !overlap) m_fill = 0;
            end
            m_y = hitm ? 1 : 0;
            if (clear_count) m_cnt = 0;
            else if (hitm && m_cnt < (1 << CW) - 1) m_cnt = m_cnt + 1;
            if (!CNT_EN) m_cnt = 0;
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    always @(negedge clock) begin
        if (chk_on) begin
            chk("model_y", int'(y), m_y);
            chk("model_state", int'(state), m_fill);
            chk("model_count", int'(match_count), m_cnt);
        end
    end

    task automatic drive(input logic en, input logic bit_i, input logic ov, input logic clr);
        enable      = en;
        a           = bit_i;
        overlap     = ov;
        clear_count = clr;
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        for (int i = 0; i < n; i++) drive(1'b1, logic'(i % 2), 1'b0, 1'b1);
        reset = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    logic [3:0] seq4 = 4'b1011;
    logic [6:0] seq7 = 7'b1011011;

    initial begin
        // Reset held two cycles with enable high and a toggling
        reset = 1'b1;
        drive(1'b1, 1'b1, 1'b0, 1'b0);
        chk_on = 1'b1;
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        chk("reset_y", int'(y), 0);
        chk("reset_state", int'(state), 0);
        chk("reset_count", int'(match_count), 0);
        reset = 1'b0;

        // Basic match, non-overlapping
        drive(1'b1, 1'b1, 1'b0, 1'b0);
        chk("basic_state1", int'(state), 1);
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        chk("basic_state2", int'(state), 2);
        drive(1'b1, 1'b1, 1'b0, 1'b0);
        chk("basic_state3", int'(state), 3);
        chk("basic_y_pre", int'(y), 0);
        drive(1'b1, 1'b1, 1'b0, 1'b0);
        chk("basic_state4", int'(state), 0);
        chk("basic_y", int'(y), 1);
        chk("basic_count", int'(match_count), CNT_EN ? 1 : 0);
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        chk("basic_y_drop", int'(y), 0);

        // Overlapping: 1011011 pulses twice
        do_reset(1);
        for (int i = 6; i >= 0; i--) begin
            drive(1'b1, seq7[i], 1'b1, 1'b0);
            if (i == 3) chk("ovl_y_bit4", int'(y), 1);
            if (i == 2) chk("ovl_y_bit5", int'(y), 0);
        end
        chk("ovl_y_bit7", int'(y), 1);
        chk("ovl_state", int'(state), 4);
        chk("ovl_count", int'(match_count), CNT_EN ? 2 : 0);

        // Non-overlapping: same stream, single pulse
        do_reset(1);
        for (int i = 6; i >= 0; i--) begin
            drive(1'b1, seq7[i], 1'b0, 1'b0);
            if (i == 3) chk("novl_y_bit4", int'(y), 1);
        end
        chk("novl_y_bit7", int'(y), 0);
        chk("novl_state", int'(state), 3);
        chk("novl_count", int'(match_count), CNT_EN ? 1 : 0);

        // Enable gaps of three cycles with random a
        do_reset(1);
        for (int i = 3; i >= 0; i--) begin
            drive(1'b1, seq4[i], 1'b0, 1'b0);
            chk("gap_y_accept", int'(y), (i == 0) ? 1 : 0);
            for (int g = 0; g < 3; g++) begin
                drive(1'b0, logic'($urandom_range(0, 1)), 1'b0, 1'b0);
                chk("gap_state_held", int'(state), (i == 0) ? 0 : 4 - i);
                chk("gap_y_low", int'(y), 0);
            end
        end

        // Counter saturation then clear on a hit cycle
        do_reset(1);
        for (int m = 0; m < 5; m++)
            for (int i = 3; i >= 0; i--) drive(1'b1, seq4[i], 1'b0, 1'b0);
        chk("sat_count", int'(match_count), CNT_EN ? 3 : 0);
        drive(1'b1, 1'b1, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 1'b0, 1'b1);
        chk("clr_hit_y", int'(y), 1);
        chk("clr_hit_count", int'(match_count), 0);
        drive(1'b0, 1'b0, 1'b0, 1'b0);

        // Reset mid-pattern discards partial history
        do_reset(1);
        drive(1'b1, 1'b1, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 1'b0, 1'b0);
        reset = 1'b1;
        drive(1'b1, 1'b1, 1'b0, 1'b0);
        reset = 1'b0;
        chk("mid_rst_state", int'(state), 0);
        drive(1'b1, 1'b1, 1'b0, 1'b0);
        chk("mid_y_first", int'(y), 0);
        chk("mid_state_first", int'(state), 1);
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 1'b0, 1'b0);
        chk("mid_y_third", int'(y), 0);
        drive(1'b1, 1'b1, 1'b0, 1'b0);
        chk("mid_y_fresh", int'(y), 1);

        // Random stretch checked by the model alone
        for (int i = 0; i < 300; i++)
            drive(logic'($urandom_range(0, 3) != 0), logic'($urandom_range(0, 1)),
                  logic'($urandom_range(0, 1)), logic'($urandom_range(0, 15) == 0));

        chk_on = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
